// File: rtl/instr_apb_loader_if.sv
// APB write-port bundle between the instruction loader (master) and the
// COREABC instruction RAM APB window (slave).
interface instr_apb_loader_if #(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 16
);
    // A transfer is one SETUP cycle (PSEL=1, PENABLE=0) followed by ACCESS
    // cycles (PSEL=1, PENABLE=1) with PADDR/PWDATA/PWRITE held stable; it
    // completes on the rising edge where PREADY=1, and PSLVERR is valid only then.
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [AWIDTH-1:0] PADDR;
    logic [DWIDTH-1:0] PWDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PREADY, PSLVERR
    );
endinterface

// File: rtl/instr_apb_loader.sv
// Streams 9-bit instruction bytes into the COREABC instruction RAM over APB.
// Define INSTR_LOADER_PAGE_CACHE_EN to skip redundant page/ninth-bit writes.
module instr_apb_loader #(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 16,
    parameter int LWIDTH = 15,
    parameter int CWIDTH = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [LWIDTH-1:0] START_ADDR,
    input  logic [CWIDTH-1:0] LEN,
    input  logic [8:0]        SDATA,
    input  logic              SVALID,
    output logic              SREADY,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERROR,
    instr_apb_loader_if.master apb,
    output logic [2:0]        dbg_state_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_ACCESS = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam logic [1:0] K_PAGE  = 2'd0;
    localparam logic [1:0] K_NINTH = 2'd1;
    localparam logic [1:0] K_DATA  = 2'd2;

    logic [2:0]        state_q, state_d;
    logic [1:0]        kind_q, kind_d;
    logic [LWIDTH-1:0] addr_q, addr_d;
    logic [CWIDTH-1:0] rem_q, rem_d;
    logic [8:0]        byte_q, byte_d;
    logic              page_dirty_q, page_dirty_d;
    logic              ninth_dirty_q, ninth_dirty_d;
    logic              error_q, error_d;
`ifdef INSTR_LOADER_PAGE_CACHE_EN
    logic              last_ninth_q, last_ninth_d;
`endif

    logic [LWIDTH-1:0] addr_inc;
    logic              pd, nd;

    // Register writes go first: page, then the ninth-bit latch (8-bit bus only).
    function automatic logic [1:0] pick_kind(input logic page_dirty, input logic ninth_dirty);
        if (page_dirty)
            return K_PAGE;
        else if (DWIDTH == 8 && ninth_dirty)
            return K_NINTH;
        else
            return K_DATA;
    endfunction

    assign addr_inc = addr_q + LWIDTH'(1);

    always_comb begin
        state_d       = state_q;
        kind_d        = kind_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        byte_d        = byte_q;
        page_dirty_d  = page_dirty_q;
        ninth_dirty_d = ninth_dirty_q;
        error_d       = error_q;
`ifdef INSTR_LOADER_PAGE_CACHE_EN
        last_ninth_d  = last_ninth_q;
`endif
        pd            = 1'b0;
        nd            = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    error_d = 1'b0;
                    if (LEN == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d       = S_WAIT;
                        addr_d        = START_ADDR;
                        rem_d         = LEN;
                        page_dirty_d  = 1'b1;
                        ninth_dirty_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (SVALID) begin
                    byte_d = SDATA;
`ifdef INSTR_LOADER_PAGE_CACHE_EN
                    pd = page_dirty_q;
                    nd = ninth_dirty_q | (SDATA[8] != last_ninth_q);
`else
                    pd = 1'b1;
                    nd = 1'b1;
`endif
                    page_dirty_d  = pd;
                    ninth_dirty_d = nd;
                    kind_d        = pick_kind(pd, nd);
                    state_d       = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (apb.PREADY) begin
                    if (apb.PSLVERR)
                        error_d = 1'b1;
                    case (kind_q)
                        K_PAGE: begin
                            page_dirty_d = 1'b0;
                            kind_d       = pick_kind(1'b0, ninth_dirty_q);
                            state_d      = S_SETUP;
                        end
                        K_NINTH: begin
                            ninth_dirty_d = 1'b0;
`ifdef INSTR_LOADER_PAGE_CACHE_EN
                            last_ninth_d  = byte_q[8];
`endif
                            kind_d        = pick_kind(page_dirty_q, 1'b0);
                            state_d       = S_SETUP;
                        end
                        default: begin
                            addr_d = addr_inc;
                            rem_d  = rem_q - CWIDTH'(1);
                            if (addr_inc[LWIDTH-1:7] != addr_q[LWIDTH-1:7])
                                page_dirty_d = 1'b1;
                            state_d = (rem_q == CWIDTH'(1)) ? S_FINISH : S_WAIT;
                        end
                    endcase
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            kind_q        <= K_PAGE;
            addr_q        <= '0;
            rem_q         <= '0;
            byte_q        <= '0;
            page_dirty_q  <= 1'b0;
            ninth_dirty_q <= 1'b0;
            error_q       <= 1'b0;
`ifdef INSTR_LOADER_PAGE_CACHE_EN
            last_ninth_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            kind_q        <= kind_d;
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            byte_q        <= byte_d;
            page_dirty_q  <= page_dirty_d;
            ninth_dirty_q <= ninth_dirty_d;
            error_q       <= error_d;
`ifdef INSTR_LOADER_PAGE_CACHE_EN
            last_ninth_q  <= last_ninth_d;
`endif
        end
    end

    // Bus outputs are zero outside a transfer so idle PADDR/PWDATA are quiet.
    always_comb begin
        apb.PSEL    = (state_q == S_SETUP) || (state_q == S_ACCESS);
        apb.PENABLE = (state_q == S_ACCESS);
        apb.PWRITE  = apb.PSEL;
        apb.PADDR   = '0;
        apb.PWDATA  = '0;
        if (apb.PSEL) begin
            case (kind_q)
                K_PAGE: begin
                    apb.PADDR  = AWIDTH'(8'h80);
                    apb.PWDATA = DWIDTH'(addr_q[LWIDTH-1:7]);
                end
                K_NINTH: begin
                    apb.PADDR  = AWIDTH'(8'h84);
                    apb.PWDATA = DWIDTH'(byte_q[8]);
                end
                default: begin
                    apb.PADDR  = AWIDTH'(addr_q[6:0]);
                    apb.PWDATA = (DWIDTH == 8) ? DWIDTH'(byte_q[7:0]) : DWIDTH'(byte_q);
                end
            endcase
        end
    end

    assign SREADY      = (state_q == S_WAIT);
    assign BUSY        = (state_q == S_WAIT) || (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign DONE        = (state_q == S_FINISH);
    assign ERROR       = error_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instr_apb_loader.sv
// Scoreboard bench for instr_apb_loader: DUT a uses a 16-bit bus, DUT b an 8-bit bus.
// Expected APB writes follow the INSTR_LOADER_PAGE_CACHE_EN setting of the build.
module tb_instr_apb_loader;

  localparam int W = 41;  // {pwrite, paddr[7:0], pwdata zero-extended to 32}

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_start, a_svalid, a_sready, a_busy, a_done, a_error;
  logic [14:0] a_saddr;
  logic [15:0] a_len;
  logic [8:0]  a_sdata;
  logic [2:0]  a_state;
  logic        b_start, b_svalid, b_sready, b_busy, b_done, b_error;
  logic [14:0] b_saddr;
  logic [15:0] b_len;
  logic [8:0]  b_sdata;
  logic [2:0]  b_state;

  instr_apb_loader_if #(.AWIDTH(8), .DWIDTH(16)) a_apb ();
  instr_apb_loader_if #(.AWIDTH(8), .DWIDTH(8))  b_apb ();

  instr_apb_loader #(.AWIDTH(8), .DWIDTH(16), .LWIDTH(15), .CWIDTH(16)) dut_a (
    .CLK(clk), .RESET(rst), .START(a_start), .START_ADDR(a_saddr), .LEN(a_len),
    .SDATA(a_sdata), .SVALID(a_svalid), .SREADY(a_sready), .BUSY(a_busy),
    .DONE(a_done), .ERROR(a_error), .apb(a_apb), .dbg_state_o(a_state)
  );

  instr_apb_loader #(.AWIDTH(8), .DWIDTH(8), .LWIDTH(15), .CWIDTH(16)) dut_b (
    .CLK(clk), .RESET(rst), .START(b_start), .START_ADDR(b_saddr), .LEN(b_len),
    .SDATA(b_sdata), .SVALID(b_svalid), .SREADY(b_sready), .BUSY(b_busy),
    .DONE(b_done), .ERROR(b_error), .apb(b_apb), .dbg_state_o(b_state)
  );

  int checks = 0;
  int passes = 0;
  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  logic [W-1:0] a_hold, b_hold;
  bit a_stall_arm = 0, a_force_stall = 0;
  int a_stall_n = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s", name);
  endtask

  // Slave responder for DUT a (optional wait states + PSLVERR on a DATA write), then monitor.
  always @(negedge clk) begin
    a_apb.PREADY  = 1'b1;
    a_apb.PSLVERR = 1'b0;
    if (a_force_stall) a_apb.PREADY = 1'b0;
    else if (a_stall_arm && a_apb.PSEL && a_apb.PENABLE && a_apb.PADDR < 8'h80) begin
      if (a_stall_n < 3) begin
        a_apb.PREADY = 1'b0;
        a_stall_n++;
      end else begin
        a_apb.PSLVERR = 1'b1;
        a_stall_arm = 0;
      end
    end
    if (!rst && a_apb.PSEL) begin
      if (!a_apb.PENABLE) a_hold = {a_apb.PWRITE, a_apb.PADDR, 32'(a_apb.PWDATA)};
      else begin
        chk("a_stable", {a_apb.PWRITE, a_apb.PADDR, 32'(a_apb.PWDATA)}, a_hold);
        if (a_apb.PREADY) begin
          if (exp_a_q.size() == 0) fail_now("a_unexpected_write");
          else chk("a_write", {a_apb.PWRITE, a_apb.PADDR, 32'(a_apb.PWDATA)}, exp_a_q.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_apb.PSEL) begin
      if (!b_apb.PENABLE) b_hold = {b_apb.PWRITE, b_apb.PADDR, 32'(b_apb.PWDATA)};
      else begin
        chk("b_stable", {b_apb.PWRITE, b_apb.PADDR, 32'(b_apb.PWDATA)}, b_hold);
        if (b_apb.PREADY) begin
          if (exp_b_q.size() == 0) fail_now("b_unexpected_write");
          else chk("b_write", {b_apb.PWRITE, b_apb.PADDR, 32'(b_apb.PWDATA)}, exp_b_q.pop_front());
        end
      end
    end
  end

  task automatic expw(input bit s, input logic [7:0] ad, input logic [31:0] d);
    if (s) exp_b_q.push_back({1'b1, ad, d});
    else   exp_a_q.push_back({1'b1, ad, d});
  endtask

  task automatic do_start(input bit s, input logic [14:0] ad, input logic [15:0] ln);
    @(negedge clk);
    if (s) begin b_start = 1; b_saddr = ad; b_len = ln; end
    else   begin a_start = 1; a_saddr = ad; a_len = ln; end
    @(posedge clk); #1;
    a_start = 0;
    b_start = 0;
  endtask

  task automatic send(input bit s, input logic [8:0] d);
    int n = 0;
    if (s) begin b_sdata = d; b_svalid = 1; end
    else   begin a_sdata = d; a_svalid = 1; end
    @(negedge clk);
    while (!(s ? b_sready : a_sready) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) fail_now("sready_timeout");
    @(posedge clk); #1;
    a_svalid = 0;
    b_svalid = 0;
  endtask

  task automatic wait_done(input bit s, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!(s ? b_done : a_done) && n < 500);
    chk("done_seen", W'(s ? b_done : a_done), W'(1));
    chk("busy_in_done", W'(s ? b_busy : a_busy), W'(0));
    @(negedge clk);
    chk("done_pulse", W'(s ? b_done : a_done), W'(0));
    chk("queue_drained", W'(s ? exp_b_q.size() : exp_a_q.size()), W'(0));
  endtask

  initial begin
    int n;
    bit seen;
    rst = 1;
    a_start = 0; a_svalid = 0; a_saddr = '0; a_len = '0; a_sdata = '0;
    b_start = 0; b_svalid = 0; b_saddr = '0; b_len = '0; b_sdata = '0;
    a_apb.PREADY = 1; a_apb.PSLVERR = 0;
    b_apb.PREADY = 1; b_apb.PSLVERR = 0;
    repeat (3) @(negedge clk);
    rst = 0;

    // Idle after reset: everything low, no bus activity.
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      seen |= a_apb.PSEL | b_apb.PSEL;
    end
    chk("idle_psel", W'(seen), W'(0));
    chk("reset_a_ctrl", W'({a_sready, a_busy, a_done, a_error, a_apb.PSEL, a_apb.PENABLE, a_apb.PWRITE}), W'(0));
    chk("reset_a_bus", W'({a_apb.PADDR, a_apb.PWDATA}), W'(0));
    chk("reset_b_ctrl", W'({b_sready, b_busy, b_done, b_error, b_apb.PSEL, b_apb.PENABLE, b_apb.PWRITE}), W'(0));
    chk("reset_b_bus", W'({b_apb.PADDR, b_apb.PWDATA}), W'(0));
    chk("reset_state", W'({a_state, b_state}), W'(0));

    // 16-bit bus, page crossing at 0x7F -> 0x80.
`ifdef INSTR_LOADER_PAGE_CACHE_EN
    expw(0, 8'h80, 32'h000); expw(0, 8'h7E, 32'h1A5); expw(0, 8'h7F, 32'h0FF);
    expw(0, 8'h80, 32'h001); expw(0, 8'h00, 32'h100);
`else
    expw(0, 8'h80, 32'h000); expw(0, 8'h7E, 32'h1A5);
    expw(0, 8'h80, 32'h000); expw(0, 8'h7F, 32'h0FF);
    expw(0, 8'h80, 32'h001); expw(0, 8'h00, 32'h100);
`endif
    do_start(0, 15'h007E, 16'd3);
    chk("sready_after_start", W'(a_sready), W'(1));
    send(0, 9'h1A5); send(0, 9'h0FF); send(0, 9'h100);
    wait_done(0, n);
    chk("t1_error", W'(a_error), W'(0));

    // 8-bit bus: ninth-bit register writes.
`ifdef INSTR_LOADER_PAGE_CACHE_EN
    expw(1, 8'h80, 32'h04); expw(1, 8'h84, 32'h1); expw(1, 8'h00, 32'h55);
    expw(1, 8'h01, 32'h56); expw(1, 8'h84, 32'h0); expw(1, 8'h02, 32'h57);
`else
    expw(1, 8'h80, 32'h04); expw(1, 8'h84, 32'h1); expw(1, 8'h00, 32'h55);
    expw(1, 8'h80, 32'h04); expw(1, 8'h84, 32'h1); expw(1, 8'h01, 32'h56);
    expw(1, 8'h80, 32'h04); expw(1, 8'h84, 32'h0); expw(1, 8'h02, 32'h57);
`endif
    do_start(1, 15'h0200, 16'd3);
    send(1, 9'h155); send(1, 9'h156); send(1, 9'h057);
    wait_done(1, n);

    // Wait states and PSLVERR on the first DATA write.
`ifdef INSTR_LOADER_PAGE_CACHE_EN
    expw(0, 8'h80, 32'h00); expw(0, 8'h10, 32'h011); expw(0, 8'h11, 32'h022);
`else
    expw(0, 8'h80, 32'h00); expw(0, 8'h10, 32'h011);
    expw(0, 8'h80, 32'h00); expw(0, 8'h11, 32'h022);
`endif
    a_stall_arm = 1; a_stall_n = 0;
    do_start(0, 15'h0010, 16'd2);
    send(0, 9'h011); send(0, 9'h022);
    wait_done(0, n);
    chk("t3_stall_cycles", W'(a_stall_n), W'(3));
    chk("t3_error_sticky", W'(a_error), W'(1));

    // Linear address wrap 0x7FFF -> 0x0000; START clears ERROR.
    expw(0, 8'h80, 32'h0FF); expw(0, 8'h7F, 32'h0AA);
    expw(0, 8'h80, 32'h000); expw(0, 8'h00, 32'h0BB);
    do_start(0, 15'h7FFF, 16'd2);
    chk("error_cleared_by_start", W'(a_error), W'(0));
    send(0, 9'h0AA); send(0, 9'h0BB);
    wait_done(0, n);

    // LEN = 0: DONE right after START, no bus writes.
    do_start(0, 15'h0123, 16'd0);
    wait_done(0, n);
    chk("len0_latency", W'(n), W'(1));

    // Reset during ACCESS.
    a_force_stall = 1;
    do_start(0, 15'h0005, 16'd2);
    send(0, 9'h033);
    n = 0;
    while (!(a_apb.PSEL && a_apb.PENABLE) && n < 50) begin @(negedge clk); n++; end
    chk("reached_access", W'(a_apb.PSEL & a_apb.PENABLE), W'(1));
    rst = 1;
    @(negedge clk);
    chk("rst_mid_ctrl", W'({a_apb.PSEL, a_apb.PENABLE, a_busy, a_done, a_error}), W'(0));
    chk("rst_mid_state", W'(a_state), W'(0));
    rst = 0;
    a_force_stall = 0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      seen |= a_done | a_apb.PSEL;
    end
    chk("rst_no_done", W'(seen), W'(0));

    expw(0, 8'h80, 32'h000); expw(0, 8'h01, 32'h1C3);
    do_start(0, 15'h0001, 16'd1);
    send(0, 9'h1C3);
    wait_done(0, n);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
